// File: rtl/zx_keymatrix_sync.sv
// ZX Spectrum keyboard matrix loaded serially by an MCU (CH446Q-style DAT/SK/STB),
// serving port #FE reads, with input synchronisers and an MCU-silence watchdog.
module zx_keymatrix_sync #(
    parameter int          NROW     = 8,
    parameter int          NCOL     = 5,
    parameter int          SPEC_AX  = 8,
    parameter int          SPEC_AY0 = 5,
    parameter int          NSPEC    = 3,
    parameter logic [23:0] TIMEOUT  = 24'd3_500_000
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             DAT,
    input  logic             SK,
    input  logic             STB,
    input  logic [15:0]      A,
    input  logic             M1,
    input  logic             RD,
    input  logic             IORQ,
    output logic [NCOL-1:0]  D,
    output logic             IORQGE,
    output logic             enable,
    output logic [NSPEC-1:0] SPECIAL,
    output logic             wd_fired
);

    localparam logic [3:0] NROW_L     = 4'(NROW);
    localparam logic [3:0] NCOL_L     = 4'(NCOL);
    localparam logic [3:0] SPEC_AX_L  = 4'(SPEC_AX);
    localparam logic [3:0] SPEC_LO_L  = 4'(SPEC_AY0);
    localparam logic [3:0] SPEC_HI_L  = 4'(SPEC_AY0 + NSPEC);

    logic [1:0]             dat_sync_q, dat_sync_d;
    logic [2:0]             sk_sync_q, sk_sync_d;
    logic [2:0]             stb_sync_q, stb_sync_d;
    logic [6:0]             sr_q, sr_d;
    logic [NROW*NCOL-1:0]   keys_q, keys_d;
    logic [NSPEC-1:0]       special_q, special_d;
    logic [23:0]            cnt_q, cnt_d;
    logic                   wd_fired_q, wd_fired_d;

    logic                   dat_s;
    logic                   sk_rise_s;
    logic                   stb_rise_s;
    logic                   wd_fire_s;
    logic [3:0]             ax_s;
    logic [2:0]             ay_s;
    logic                   key_hit_s;
    logic                   spec_hit_s;
    logic [NCOL-1:0]        d_s;
    logic                   iorqge_s;
    logic                   unused_s;

    assign dat_s      = dat_sync_q[1];
    assign sk_rise_s  = sk_sync_q[1] & ~sk_sync_q[2];
    assign stb_rise_s = stb_sync_q[1] & ~stb_sync_q[2];
    assign ax_s       = sr_q[3:0];
    assign ay_s       = sr_q[6:4];
    assign key_hit_s  = (ax_s < NROW_L) && ({1'b0, ay_s} < NCOL_L);
    assign spec_hit_s = (ax_s == SPEC_AX_L) && ({1'b0, ay_s} >= SPEC_LO_L)
                        && ({1'b0, ay_s} < SPEC_HI_L);
    // Only bits 0 and 8+r of the address take part in decoding.
    assign unused_s   = ^A;

    // Synchroniser chains, shift register, matrix and watchdog next-state.
    always_comb begin
        dat_sync_d = {dat_sync_q[0], DAT};
        sk_sync_d  = {sk_sync_q[1:0], SK};
        stb_sync_d = {stb_sync_q[1:0], STB};
        sr_d       = sr_q;
        keys_d     = keys_q;
        special_d  = special_q;
        cnt_d      = cnt_q;
        wd_fire_s  = 1'b0;
        wd_fired_d = 1'b0;

        if (sk_rise_s) begin
            sr_d = {sr_q[5:0], dat_s};
        end else begin
            sr_d = sr_q;
        end

        // Commit decodes the address held before any same-cycle shift.
        if (stb_rise_s) begin
            for (int r = 0; r < NROW; r++) begin
                for (int c = 0; c < NCOL; c++) begin
                    if (key_hit_s && (ax_s == 4'(r)) && (ay_s == 3'(c))) begin
                        keys_d[r*NCOL+c] = ~dat_s;
                    end else begin
                        keys_d[r*NCOL+c] = keys_q[r*NCOL+c];
                    end
                end
            end
            for (int s = 0; s < NSPEC; s++) begin
                if (spec_hit_s && ({1'b0, ay_s} == 4'(SPEC_AY0 + s))) begin
                    special_d[s] = dat_s;
                end else begin
                    special_d[s] = special_q[s];
                end
            end
            cnt_d = 24'd0;
        end else if (TIMEOUT == 24'd0) begin
            cnt_d = 24'd0;
        end else if (cnt_q != TIMEOUT) begin
            cnt_d     = cnt_q + 24'd1;
            wd_fire_s = (cnt_q == (TIMEOUT - 24'd1));
        end else begin
            cnt_d = cnt_q;
        end

        if (wd_fire_s) begin
            keys_d     = '1;
            special_d  = '0;
            wd_fired_d = 1'b1;
        end else begin
            wd_fired_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            dat_sync_q <= 2'b00;
            sk_sync_q  <= 3'b000;
            stb_sync_q <= 3'b000;
            sr_q       <= 7'd0;
            keys_q     <= '1;
            special_q  <= '0;
            cnt_q      <= 24'd0;
            wd_fired_q <= 1'b0;
        end else begin
            dat_sync_q <= dat_sync_d;
            sk_sync_q  <= sk_sync_d;
            stb_sync_q <= stb_sync_d;
            sr_q       <= sr_d;
            keys_q     <= keys_d;
            special_q  <= special_d;
            cnt_q      <= cnt_d;
            wd_fired_q <= wd_fired_d;
        end
    end

    // Half-row read: a row contributes only while its address line is low.
    always_comb begin
        d_s = '1;
        for (int r = 0; r < NROW; r++) begin
            d_s = d_s & (keys_q[r*NCOL +: NCOL] | {NCOL{A[8+r]}});
        end
    end

    assign iorqge_s = A[0] | RD | ~M1;
    assign D        = d_s;
    assign IORQGE   = iorqge_s;
    assign enable   = ~(iorqge_s | IORQ);
    assign SPECIAL  = special_q;
    assign wd_fired = wd_fired_q;

endmodule
